// File: rtl/game_pkg.sv
// Shared types and helpers for the whack-a-mole game timer.
// Holds timer state encoding and BCD/ASCII utilities.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int MAX_DIGITS = 16;

  function automatic logic [7:0] bcd_to_ascii(
    input logic [3:0] d
  );
    return ASCII_ZERO + {4'h0, d};
  endfunction

  function automatic logic [4*MAX_DIGITS-1:0] all_nines(
    input int digits
  );
    logic [4*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < digits) r[4*i+:4] = 4'h9;
    return r;
  endfunction

endpackage

// File: rtl/bcd_sat_addsub.sv
// Packed-BCD add with all-nines saturation, then optional -1.
// Purely combinational; one digit-ripple chain for each step.
module bcd_sat_addsub
  import game_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                dec,
  output logic [4*DIGITS-1:0] y
);

  localparam int W = 4*DIGITS;
  localparam logic [W-1:0] NINES = W'(all_nines(DIGITS));

  logic [W-1:0] sum;
  logic [4:0]   s;
  logic         c;
  logic         br;

  always_comb begin
    sum = '0;
    s   = '0;
    c   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]}
        + {4'h0, c};
      c = (s > 5'd9);
      if (c) s = s - 5'd10;
      sum[4*i+:4] = s[3:0];
    end
    if (c) sum = NINES;

    y  = sum;
    br = dec;
    for (int i = 0; i < DIGITS; i++) begin
      if (br) begin
        if (y[4*i+:4] == 4'h0) begin
          y[4*i+:4] = 4'h9;
        end else begin
          y[4*i+:4] = y[4*i+:4] - 4'h1;
          br = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with prescaler, pause and bonus time.
// Drives ASCII digits to the overlay and done/warn flags to the game.
module bcd_countdown_timer
  import game_pkg::*;
#(
  parameter int                DIGITS    = 2,
  parameter logic [4*DIGITS-1:0] START_BCD = 'h31,
  parameter int                TICK_DIV  = 100_000_000,
  parameter logic [4*DIGITS-1:0] WARN_BCD  = 'h05
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                bonus_valid,
  input  logic [4*DIGITS-1:0] bonus_bcd,
  output logic [4*DIGITS-1:0] time_bcd,
  output logic [8*DIGITS-1:0] time_ascii,
  output logic                running,
  output logic                timer_done,
  output logic                done_pulse,
  output logic                warn,
  output logic                sec_tick
);

  localparam int W  = 4*DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);

  function automatic logic [8*DIGITS-1:0] to_ascii(
    input logic [W-1:0] v
  );
    logic [8*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[8*i+:8] = bcd_to_ascii(v[4*i+:4]);
    return r;
  endfunction

  localparam logic [8*DIGITS-1:0] START_ASCII =
    to_ascii(START_BCD);
  localparam logic START_ZERO = (START_BCD == '0);

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [W-1:0]  value_nx, add_b, sum_y;
  logic          active, cnt_en, tick, bonus_en;
  logic          done_nx, warn_nx, run_nx;

  // A released pause counts its cycle, so the held
  // prescaler phase is preserved exactly across a pause.
  always_comb begin
    active   = (state == ST_RUN) || (state == ST_PAUSED);
    cnt_en   = active && !pause && !start;
    tick     = cnt_en && (presc == P_TOP);
    bonus_en = active && bonus_valid && !start;
    add_b    = bonus_en ? bonus_bcd : '0;
  end

  bcd_sat_addsub #(
    .DIGITS(DIGITS)
  ) u_addsub (
    .a  (time_bcd),
    .b  (add_b),
    .dec(tick),
    .y  (sum_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = START_ZERO ? ST_DONE : ST_RUN;
    end else begin
      unique case (state)
        ST_RUN, ST_PAUSED: begin
          if (pause)
            state_nx = ST_PAUSED;
          else if (tick && sum_y == '0)
            state_nx = ST_DONE;
          else
            state_nx = ST_RUN;
        end
        ST_IDLE, ST_DONE: state_nx = state;
        default:          state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    value_nx = time_bcd;
    presc_nx = presc;
    if (start) begin
      value_nx = START_BCD;
      presc_nx = '0;
    end else begin
      if (bonus_en || tick) value_nx = sum_y;
      if (cnt_en) presc_nx = tick ? '0 : presc + PW'(1);
    end
    run_nx  = (state_nx == ST_RUN);
    done_nx = (state_nx == ST_DONE)
           && (start || state != ST_DONE);
    warn_nx = ((state_nx == ST_RUN) || (state_nx == ST_PAUSED))
           && (value_nx != '0) && (value_nx <= WARN_BCD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      time_bcd   <= START_BCD;
      time_ascii <= START_ASCII;
      running    <= 1'b0;
      timer_done <= 1'b0;
      done_pulse <= 1'b0;
      warn       <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      presc      <= presc_nx;
      time_bcd   <= value_nx;
      time_ascii <= to_ascii(value_nx);
      running    <= run_nx;
      timer_done <= (state_nx == ST_DONE);
      done_pulse <= done_nx;
      warn       <= warn_nx;
      sec_tick   <= tick;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: integer reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bcd_countdown_timer;

  localparam int TDIV  = 4;
  localparam int SINT  = 12;
  localparam int WINT  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pause, bonus_valid;
  logic [7:0]  bonus_bcd;
  logic [7:0]  time_bcd;
  logic [15:0] time_ascii;
  logic        running, timer_done, done_pulse, warn, sec_tick;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_countdown_timer #(
    .DIGITS   (2),
    .START_BCD(8'h12),
    .TICK_DIV (TDIV),
    .WARN_BCD (8'h05)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .bonus_valid(bonus_valid),
    .bonus_bcd  (bonus_bcd),
    .time_bcd   (time_bcd),
    .time_ascii (time_ascii),
    .running    (running),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .warn       (warn),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] i2bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] i2asc(input int v);
    return 16'(16'h3030 + (v / 10) * 256 + (v % 10));
  endfunction

  // Reference model: remaining time as a plain integer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_st   = M_IDLE;
  int m_val  = SINT;
  int m_cnt  = 0;
  int m_tick = 0;
  int m_dp   = 0;
  int v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = M_IDLE; m_val = SINT; m_cnt = 0;
      m_tick = 0; m_dp = 0;
    end else begin
      m_tick = 0; m_dp = 0;
      if (start) begin
        m_val = SINT; m_cnt = 0;
        m_st  = (SINT == 0) ? M_DONE : M_RUN;
        m_dp  = (SINT == 0) ? 1 : 0;
      end else if (m_st == M_RUN || m_st == M_PAUSED) begin
        v = m_val;
        if (bonus_valid) v = v + bcd2i(bonus_bcd);
        if (v > 99) v = 99;
        if (pause) begin
          m_st = M_PAUSED;
        end else begin
          m_st = M_RUN;
          m_cnt++;
          if (m_cnt == TDIV) begin
            m_cnt = 0; m_tick = 1; v = v - 1;
            if (v == 0) begin m_st = M_DONE; m_dp = 1; end
          end
        end
        m_val = v;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_time", time_bcd, i2bcd(m_val));
    chk("m_ascii", time_ascii, i2asc(m_val));
    chk("m_running", running, m_st == M_RUN);
    chk("m_done", timer_done, m_st == M_DONE);
    chk("m_dpulse", done_pulse, m_dp != 0);
    chk("m_tick", sec_tick, m_tick != 0);
    chk("m_warn", warn, (m_st == M_RUN || m_st == M_PAUSED)
        && m_val > 0 && m_val <= WINT);
  end

  task automatic step(input logic s, input logic p,
                      input logic bv, input logic [7:0] b);
    @(negedge clk);
    start = s; pause = p; bonus_valid = bv; bonus_bcd = b;
  endtask

  task automatic wait_val(input logic [7:0] want);
    int n = 0;
    while (time_bcd !== want && n < 2000) begin
      step(0, 0, 0, 8'h00);
      n++;
    end
    chk("wait_val", time_bcd, want);
  endtask

  int ticks, dones, hold_ticks;
  logic seen_borrow;
  logic [7:0] prev;

  initial begin
    rst = 1'b1; start = 0; pause = 0;
    bonus_valid = 0; bonus_bcd = 8'h00;
    #3;
    chk("rst_time", time_bcd, 8'h12);
    chk("rst_ascii", time_ascii, 16'h3132);
    chk("rst_flags", {running, timer_done, done_pulse, warn,
        sec_tick}, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(0, 0, 1, 8'h05);
    step(0, 0, 0, 8'h00);
    chk("idle_bonus", time_bcd, 8'h12);

    // Full countdown 12 -> 00
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("start_run", running, 1'b1);
    ticks = 0; dones = 0; seen_borrow = 0; prev = time_bcd;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 2) chk("pre_dec", time_bcd, 8'h12);
      if (i == 3) chk("first_dec", time_bcd, 8'h11);
      if (sec_tick) ticks++;
      if (done_pulse) begin
        dones++;
        chk("done_w_tick", sec_tick, 1'b1);
      end
      if (prev == 8'h10 && time_bcd == 8'h09) begin
        seen_borrow = 1;
        chk("borrow_ascii", time_ascii, 16'h3039);
      end
      if (prev == 8'h06 && time_bcd == 8'h05)
        chk("warn_rise", warn, 1'b1);
      if (time_bcd == 8'h06) chk("warn_06", warn, 1'b0);
      prev = time_bcd;
    end
    chk("n_ticks", ticks, 12);
    chk("n_dones", dones, 1);
    chk("borrow_seen", seen_borrow, 1'b1);
    chk("end_time", time_bcd, 8'h00);
    chk("end_ascii", time_ascii, 16'h3030);
    chk("end_warn", warn, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_sticky", timer_done, 1'b1);
    chk("done_once", done_pulse, 1'b0);

    // Restart from DONE, then pause after two counted cycles
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("restart_clr", timer_done, 1'b0);
    chk("restart_val", time_bcd, 8'h12);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    hold_ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 8'h00);
      if (sec_tick) hold_ticks++;
    end
    chk("pause_noticks", hold_ticks, 0);
    chk("pause_state", running, 1'b0);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("resume_1", time_bcd, 8'h12);
    step(0, 0, 0, 8'h00);
    chk("resume_2", time_bcd, 8'h11);
    chk("resume_tick", sec_tick, 1'b1);

    // Saturating bonus
    wait_val(8'h08);
    step(0, 0, 1, 8'h95);
    step(0, 0, 0, 8'h00);
    chk("bonus_sat", time_bcd, 8'h99);
    chk("bonus_ascii", time_ascii, 16'h3939);

    // Bonus coincident with final tick
    wait_val(8'h01);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h03);
    step(0, 0, 0, 8'h00);
    chk("bonus_tick", time_bcd, 8'h03);
    chk("bonus_tick_st", sec_tick, 1'b1);
    chk("bonus_nodone", {timer_done, done_pulse}, 2'b00);

    // Start while paused
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    wait_val(8'h07);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("paused_07", {running, time_bcd}, {1'b0, 8'h07});
    step(1, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("start_paused", {running, time_bcd}, {1'b1, 8'h12});

    // Asynchronous reset mid-count
    wait_val(8'h04);
    step(0, 0, 0, 8'h00);
    chk("warn_04", warn, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_time", time_bcd, 8'h12);
    chk("arst_ascii", time_ascii, 16'h3132);
    chk("arst_flags", {running, timer_done, done_pulse, warn,
        sec_tick}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("post_rst_idle", {running, time_bcd}, {1'b0, 8'h12});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
